// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: opcodes, ALU codes, sequencer states, instruction classes
// and the strobe bundle produced by the output decode.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_MFHI = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11111;

    typedef enum logic [3:0] {
        RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_IMM, CLS_MULDIV, CLS_LD, CLS_LDI, CLS_ST, CLS_BR, CLS_JR,
        CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       G_ra;
        logic       G_rb;
        logic       G_rc;
        logic       R_in;
        logic       R_out;
        logic       BA_out;
        logic       HI_en;
        logic       LO_en;
        logic       Zhi_en;
        logic       Zlo_en;
        logic       PC_en;
        logic       MDR_en;
        logic       InPort_en;
        logic       C_en;
        logic       HI_write_enable;
        logic       LO_write_enable;
        logic       Z_write_enable;
        logic       PC_write_enable;
        logic       MDR_write_enable;
        logic       MAR_write_enable;
        logic       Y_write_enable;
        logic       IR_write_enable;
        logic       OutPort_write_enable;
        logic       mem_read_enable;
        logic       mem_write_enable;
        logic       CON_en;
        logic [4:0] ALU_signals;
        logic       run;
        logic       illegal_op;
    } ctrl_t;

    // Groups opcodes that share the same execute-step sequence.
    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t c;
        c = CLS_ILLEGAL;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: c = CLS_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:                      c = CLS_IMM;
            OP_MUL, OP_DIV:                                c = CLS_MULDIV;
            OP_LD:                                         c = CLS_LD;
            OP_LDI:                                        c = CLS_LDI;
            OP_ST:                                         c = CLS_ST;
            OP_BR:                                         c = CLS_BR;
            OP_JR:                                         c = CLS_JR;
            OP_IN:                                         c = CLS_IN;
            OP_OUT:                                        c = CLS_OUT;
            OP_MFHI:                                       c = CLS_MFHI;
            OP_MFLO:                                       c = CLS_MFLO;
            OP_NOP:                                        c = CLS_NOP;
            OP_HALT:                                       c = CLS_HALT;
            default:                                       c = CLS_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/condition/halt inputs and all control strobes.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;

    logic [31:0] ir;
    logic        con_out;
    logic        stop;

    logic        G_ra, G_rb, G_rc, R_in, R_out, BA_out;
    logic        HI_en, LO_en, Zhi_en, Zlo_en, PC_en, MDR_en, InPort_en, C_en;
    logic        HI_write_enable, LO_write_enable, Z_write_enable, PC_write_enable;
    logic        MDR_write_enable, MAR_write_enable, Y_write_enable, IR_write_enable;
    logic        OutPort_write_enable;
    logic        mem_read_enable, mem_write_enable, CON_en;
    logic [4:0]  ALU_signals;
    logic        run;
    logic        illegal_op;

    modport master (
        input  ir, con_out, stop,
        output G_ra, G_rb, G_rc, R_in, R_out, BA_out,
        output HI_en, LO_en, Zhi_en, Zlo_en, PC_en, MDR_en, InPort_en, C_en,
        output HI_write_enable, LO_write_enable, Z_write_enable, PC_write_enable,
        output MDR_write_enable, MAR_write_enable, Y_write_enable, IR_write_enable,
        output OutPort_write_enable,
        output mem_read_enable, mem_write_enable, CON_en,
        output ALU_signals, run, illegal_op
    );

    modport slave (
        output ir, con_out, stop,
        input  G_ra, G_rb, G_rc, R_in, R_out, BA_out,
        input  HI_en, LO_en, Zhi_en, Zlo_en, PC_en, MDR_en, InPort_en, C_en,
        input  HI_write_enable, LO_write_enable, Z_write_enable, PC_write_enable,
        input  MDR_write_enable, MAR_write_enable, Y_write_enable, IR_write_enable,
        input  OutPort_write_enable,
        input  mem_read_enable, mem_write_enable, CON_en,
        input  ALU_signals, run, illegal_op
    );

endinterface

// File: rtl/seq_decode.sv
// Combinational strobe decode from the current sequencer state and opcode.
// Zero latency: every strobe is valid only for the cycle the state is held.
module seq_decode
    import cpu_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    input  logic       con_out_i,
    output ctrl_t      ctrl_o
);

    op_class_t cls;
    assign cls = op_class(opcode_i);

    always_comb begin
        ctrl_o     = '0;
        ctrl_o.run = (state_i != RESET) && (state_i != HALT);
        case (state_i)
            T0: begin
                ctrl_o.PC_en            = 1'b1;
                ctrl_o.MAR_write_enable = 1'b1;
                ctrl_o.ALU_signals      = ALU_INC;
                ctrl_o.Z_write_enable   = 1'b1;
            end
            T1: begin
                ctrl_o.Zlo_en           = 1'b1;
                ctrl_o.PC_write_enable  = 1'b1;
                ctrl_o.mem_read_enable  = 1'b1;
                ctrl_o.MDR_write_enable = 1'b1;
            end
            T2: begin
                ctrl_o.MDR_en          = 1'b1;
                ctrl_o.IR_write_enable = 1'b1;
            end
            T3: begin
                case (cls)
                    CLS_ALU, CLS_IMM: begin
                        ctrl_o.G_rb = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.Y_write_enable = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl_o.G_ra = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.Y_write_enable = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_o.G_rb = 1'b1; ctrl_o.BA_out = 1'b1; ctrl_o.Y_write_enable = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.G_ra = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.CON_en = 1'b1;
                    end
                    CLS_JR: begin
                        ctrl_o.G_ra = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.PC_write_enable = 1'b1;
                    end
                    CLS_IN: begin
                        ctrl_o.InPort_en = 1'b1; ctrl_o.G_ra = 1'b1; ctrl_o.R_in = 1'b1;
                    end
                    CLS_OUT: begin
                        ctrl_o.G_ra = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.OutPort_write_enable = 1'b1;
                    end
                    CLS_MFHI: begin
                        ctrl_o.HI_en = 1'b1; ctrl_o.G_ra = 1'b1; ctrl_o.R_in = 1'b1;
                    end
                    CLS_MFLO: begin
                        ctrl_o.LO_en = 1'b1; ctrl_o.G_ra = 1'b1; ctrl_o.R_in = 1'b1;
                    end
                    CLS_ILLEGAL: ctrl_o.illegal_op = 1'b1;
                    default: ;
                endcase
            end
            T4: begin
                case (cls)
                    CLS_ALU, CLS_MULDIV: begin
                        // Register ops read rc; mul/div already latched ra into Y, so read rb.
                        ctrl_o.G_rc           = (cls == CLS_ALU);
                        ctrl_o.G_rb           = (cls == CLS_MULDIV);
                        ctrl_o.R_out          = 1'b1;
                        ctrl_o.ALU_signals    = opcode_i;
                        ctrl_o.Z_write_enable = 1'b1;
                    end
                    CLS_IMM: begin
                        ctrl_o.C_en = 1'b1; ctrl_o.ALU_signals = opcode_i; ctrl_o.Z_write_enable = 1'b1;
                    end
                    CLS_LD, CLS_LDI, CLS_ST: begin
                        ctrl_o.C_en = 1'b1; ctrl_o.ALU_signals = ALU_ADD; ctrl_o.Z_write_enable = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.PC_en = 1'b1; ctrl_o.Y_write_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: begin
                        ctrl_o.Zlo_en = 1'b1; ctrl_o.G_ra = 1'b1; ctrl_o.R_in = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl_o.Zlo_en = 1'b1; ctrl_o.LO_write_enable = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        ctrl_o.Zlo_en = 1'b1; ctrl_o.MAR_write_enable = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.C_en = 1'b1; ctrl_o.ALU_signals = ALU_ADD; ctrl_o.Z_write_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (cls)
                    CLS_MULDIV: begin
                        ctrl_o.Zhi_en = 1'b1; ctrl_o.HI_write_enable = 1'b1;
                    end
                    CLS_LD: begin
                        ctrl_o.mem_read_enable = 1'b1; ctrl_o.MDR_write_enable = 1'b1;
                    end
                    CLS_ST: begin
                        ctrl_o.G_ra = 1'b1; ctrl_o.R_out = 1'b1; ctrl_o.MDR_write_enable = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl_o.Zlo_en          = 1'b1;
                        ctrl_o.PC_write_enable = con_out_i;
                    end
                    default: ;
                endcase
            end
            T7: begin
                case (cls)
                    CLS_LD: begin
                        ctrl_o.MDR_en = 1'b1; ctrl_o.G_ra = 1'b1; ctrl_o.R_in = 1'b1;
                    end
                    CLS_ST:  ctrl_o.mem_write_enable = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer: RESET -> fetch T0-T2 -> execute T3-T7 -> T0, or HALT.
// Strobes are a zero-latency decode of the current state; stop is honoured only at T0 return.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    control_sequencer_if.master bus
);

    state_t     state_q, state_d;
    state_t     ret_state;
    op_class_t  cls;
    ctrl_t      ctrl;
    logic       unused_ir_low;

    assign cls           = op_class(bus.ir[31:27]);
    assign ret_state     = bus.stop ? HALT : T0;
    assign unused_ir_low = ^bus.ir[26:0];

    always_ff @(posedge clk) begin
        if (reset) state_q <= RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET: state_d = T0;
            T0:    state_d = T1;
            T1:    state_d = T2;
            T2:    state_d = T3;
            T3: begin
                case (cls)
                    CLS_HALT: state_d = HALT;
                    CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_ILLEGAL:
                        state_d = ret_state;
                    default:  state_d = T4;
                endcase
            end
            T4:    state_d = T5;
            T5: begin
                case (cls)
                    CLS_ALU, CLS_IMM, CLS_LDI: state_d = ret_state;
                    default:                   state_d = T6;
                endcase
            end
            T6: begin
                case (cls)
                    CLS_LD, CLS_ST: state_d = T7;
                    default:        state_d = ret_state;
                endcase
            end
            T7:    state_d = ret_state;
            HALT:  state_d = HALT;
            default: state_d = RESET;
        endcase
    end

    seq_decode u_decode (
        .state_i   (state_q),
        .opcode_i  (bus.ir[31:27]),
        .con_out_i (bus.con_out),
        .ctrl_o    (ctrl)
    );

    assign bus.G_ra                 = ctrl.G_ra;
    assign bus.G_rb                 = ctrl.G_rb;
    assign bus.G_rc                 = ctrl.G_rc;
    assign bus.R_in                 = ctrl.R_in;
    assign bus.R_out                = ctrl.R_out;
    assign bus.BA_out               = ctrl.BA_out;
    assign bus.HI_en                = ctrl.HI_en;
    assign bus.LO_en                = ctrl.LO_en;
    assign bus.Zhi_en               = ctrl.Zhi_en;
    assign bus.Zlo_en               = ctrl.Zlo_en;
    assign bus.PC_en                = ctrl.PC_en;
    assign bus.MDR_en               = ctrl.MDR_en;
    assign bus.InPort_en            = ctrl.InPort_en;
    assign bus.C_en                 = ctrl.C_en;
    assign bus.HI_write_enable      = ctrl.HI_write_enable;
    assign bus.LO_write_enable      = ctrl.LO_write_enable;
    assign bus.Z_write_enable       = ctrl.Z_write_enable;
    assign bus.PC_write_enable      = ctrl.PC_write_enable;
    assign bus.MDR_write_enable     = ctrl.MDR_write_enable;
    assign bus.MAR_write_enable     = ctrl.MAR_write_enable;
    assign bus.Y_write_enable       = ctrl.Y_write_enable;
    assign bus.IR_write_enable      = ctrl.IR_write_enable;
    assign bus.OutPort_write_enable = ctrl.OutPort_write_enable;
    assign bus.mem_read_enable      = ctrl.mem_read_enable;
    assign bus.mem_write_enable     = ctrl.mem_write_enable;
    assign bus.CON_en               = ctrl.CON_en;
    assign bus.ALU_signals          = ctrl.ALU_signals;
    assign bus.run                  = ctrl.run;
    assign bus.illegal_op           = ctrl.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class step by step against
// hand-written strobe masks, then exercises halt, stop at the boundary and mid-instruction reset.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam logic [25:0] GRA   = 26'h1 << 25;
    localparam logic [25:0] GRB   = 26'h1 << 24;
    localparam logic [25:0] GRC   = 26'h1 << 23;
    localparam logic [25:0] RIN   = 26'h1 << 22;
    localparam logic [25:0] ROUT  = 26'h1 << 21;
    localparam logic [25:0] BAO   = 26'h1 << 20;
    localparam logic [25:0] HIEN  = 26'h1 << 19;
    localparam logic [25:0] LOEN  = 26'h1 << 18;
    localparam logic [25:0] ZHI   = 26'h1 << 17;
    localparam logic [25:0] ZLO   = 26'h1 << 16;
    localparam logic [25:0] PCEN  = 26'h1 << 15;
    localparam logic [25:0] MDREN = 26'h1 << 14;
    localparam logic [25:0] INP   = 26'h1 << 13;
    localparam logic [25:0] CEN   = 26'h1 << 12;
    localparam logic [25:0] HIW   = 26'h1 << 11;
    localparam logic [25:0] LOW   = 26'h1 << 10;
    localparam logic [25:0] ZW    = 26'h1 << 9;
    localparam logic [25:0] PCW   = 26'h1 << 8;
    localparam logic [25:0] MDRW  = 26'h1 << 7;
    localparam logic [25:0] MARW  = 26'h1 << 6;
    localparam logic [25:0] YW    = 26'h1 << 5;
    localparam logic [25:0] IRW   = 26'h1 << 4;
    localparam logic [25:0] OUTW  = 26'h1 << 3;
    localparam logic [25:0] MRD   = 26'h1 << 2;
    localparam logic [25:0] MWR   = 26'h1 << 1;
    localparam logic [25:0] CONEN = 26'h1;
    localparam logic [25:0] NONE  = 26'h0;

    function automatic logic [25:0] strobes();
        return {bus.G_ra, bus.G_rb, bus.G_rc, bus.R_in, bus.R_out, bus.BA_out,
                bus.HI_en, bus.LO_en, bus.Zhi_en, bus.Zlo_en, bus.PC_en, bus.MDR_en,
                bus.InPort_en, bus.C_en, bus.HI_write_enable, bus.LO_write_enable,
                bus.Z_write_enable, bus.PC_write_enable, bus.MDR_write_enable,
                bus.MAR_write_enable, bus.Y_write_enable, bus.IR_write_enable,
                bus.OutPort_write_enable, bus.mem_read_enable, bus.mem_write_enable,
                bus.CON_en};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input state_t st, input logic [25:0] strb,
                        input logic [4:0] alu, input logic ill);
        check({tag, ".state"}, 32'(dut.state_q), 32'(st));
        check({tag, ".strb"},  32'(strobes()), 32'(strb));
        check({tag, ".alu"},   32'(bus.ALU_signals), 32'(alu));
        check({tag, ".run"},   32'(bus.run), 32'((st != RESET) && (st != HALT)));
        check({tag, ".ill"},   32'(bus.illegal_op), 32'(ill));
    endtask

    // Expects to be called in T0; leaves the sequencer in T3.
    task automatic fetch(input string tag, input logic [31:0] irv);
        bus.ir = irv;
        step({tag, ".T0"}, T0, PCEN | MARW | ZW, 5'b11111, 1'b0); tick();
        step({tag, ".T1"}, T1, ZLO | PCW | MRD | MDRW, 5'b00000, 1'b0); tick();
        step({tag, ".T2"}, T2, MDREN | IRW, 5'b00000, 1'b0); tick();
    endtask

    task automatic single(input string tag, input logic [31:0] irv, input logic [25:0] t3,
                          input logic ill);
        fetch(tag, irv);
        step({tag, ".T3"}, T3, t3, 5'b00000, ill); tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; bus.ir = '0; bus.con_out = 1'b0; bus.stop = 1'b0;
        tick(); tick();
        step("rst", RESET, NONE, 5'b00000, 1'b0);
        reset = 1'b0;
        tick();

        fetch("add", 32'h1800_0000);
        step("add.T3", T3, GRB | ROUT | YW, 5'b00000, 1'b0); tick();
        step("add.T4", T4, GRC | ROUT | ZW, 5'b00011, 1'b0); tick();
        step("add.T5", T5, ZLO | GRA | RIN, 5'b00000, 1'b0); tick();

        fetch("addi", 32'h6000_0000);
        step("addi.T3", T3, GRB | ROUT | YW, 5'b00000, 1'b0); tick();
        step("addi.T4", T4, CEN | ZW, 5'b01100, 1'b0); tick();
        step("addi.T5", T5, ZLO | GRA | RIN, 5'b00000, 1'b0); tick();

        fetch("mul", 32'h7800_0000);
        step("mul.T3", T3, GRA | ROUT | YW, 5'b00000, 1'b0); tick();
        step("mul.T4", T4, GRB | ROUT | ZW, 5'b01111, 1'b0); tick();
        step("mul.T5", T5, ZLO | LOW, 5'b00000, 1'b0); tick();
        step("mul.T6", T6, ZHI | HIW, 5'b00000, 1'b0); tick();

        fetch("ld", 32'h0000_0000);
        step("ld.T3", T3, GRB | BAO | YW, 5'b00000, 1'b0); tick();
        step("ld.T4", T4, CEN | ZW, 5'b00011, 1'b0); tick();
        step("ld.T5", T5, ZLO | MARW, 5'b00000, 1'b0); tick();
        step("ld.T6", T6, MRD | MDRW, 5'b00000, 1'b0); tick();
        step("ld.T7", T7, MDREN | GRA | RIN, 5'b00000, 1'b0); tick();

        fetch("ldi", 32'h0800_0000);
        step("ldi.T3", T3, GRB | BAO | YW, 5'b00000, 1'b0); tick();
        step("ldi.T4", T4, CEN | ZW, 5'b00011, 1'b0); tick();
        step("ldi.T5", T5, ZLO | GRA | RIN, 5'b00000, 1'b0); tick();

        fetch("st", 32'h1000_0000);
        step("st.T3", T3, GRB | BAO | YW, 5'b00000, 1'b0); tick();
        step("st.T4", T4, CEN | ZW, 5'b00011, 1'b0); tick();
        step("st.T5", T5, ZLO | MARW, 5'b00000, 1'b0); tick();
        step("st.T6", T6, GRA | ROUT | MDRW, 5'b00000, 1'b0); tick();
        step("st.T7", T7, MWR, 5'b00000, 1'b0); tick();

        fetch("br0", 32'h9000_0000);
        step("br0.T3", T3, GRA | ROUT | CONEN, 5'b00000, 1'b0); tick();
        step("br0.T4", T4, PCEN | YW, 5'b00000, 1'b0); tick();
        step("br0.T5", T5, CEN | ZW, 5'b00011, 1'b0); tick();
        step("br0.T6", T6, ZLO, 5'b00000, 1'b0); tick();

        fetch("br1", 32'h9000_0000);
        bus.con_out = 1'b1;
        step("br1.T3", T3, GRA | ROUT | CONEN, 5'b00000, 1'b0); tick();
        step("br1.T4", T4, PCEN | YW, 5'b00000, 1'b0); tick();
        step("br1.T5", T5, CEN | ZW, 5'b00011, 1'b0); tick();
        step("br1.T6", T6, ZLO | PCW, 5'b00000, 1'b0); tick();
        bus.con_out = 1'b0;

        single("jr",    32'h9800_0000, GRA | ROUT | PCW, 1'b0);
        single("in",    32'hA800_0000, INP | GRA | RIN, 1'b0);
        single("out",   32'hB000_0000, GRA | ROUT | OUTW, 1'b0);
        single("mfhi",  32'hB800_0000, HIEN | GRA | RIN, 1'b0);
        single("mflo",  32'hC000_0000, LOEN | GRA | RIN, 1'b0);
        single("nop",   32'hC800_0000, NONE, 1'b0);
        single("ill31", 32'hF800_0000, NONE, 1'b1);
        single("ill09", 32'h4800_0000, NONE, 1'b1);

        fetch("halt", 32'hD000_0000);
        step("halt.T3", T3, NONE, 5'b00000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            step("halt.hold", HALT, NONE, 5'b00000, 1'b0);
        end
        reset = 1'b1; tick();
        step("halt.rst", RESET, NONE, 5'b00000, 1'b0);
        reset = 1'b0; tick();

        fetch("stop", 32'h1800_0000);
        step("stop.T3", T3, GRB | ROUT | YW, 5'b00000, 1'b0); tick();
        step("stop.T4", T4, GRC | ROUT | ZW, 5'b00011, 1'b0);
        bus.stop = 1'b1; tick();
        step("stop.T5", T5, ZLO | GRA | RIN, 5'b00000, 1'b0); tick();
        step("stop.halt", HALT, NONE, 5'b00000, 1'b0);
        bus.stop = 1'b0; tick();
        step("stop.hold", HALT, NONE, 5'b00000, 1'b0);
        reset = 1'b1; tick();
        reset = 1'b0; tick();

        fetch("ldr", 32'h0000_0000);
        step("ldr.T3", T3, GRB | BAO | YW, 5'b00000, 1'b0); tick();
        step("ldr.T4", T4, CEN | ZW, 5'b00011, 1'b0); tick();
        step("ldr.T5", T5, ZLO | MARW, 5'b00000, 1'b0); tick();
        step("ldr.T6", T6, MRD | MDRW, 5'b00000, 1'b0);
        reset = 1'b1; tick();
        step("ldr.rst", RESET, NONE, 5'b00000, 1'b0);
        reset = 1'b0; tick();
        step("ldr.T0", T0, PCEN | MARW | ZW, 5'b11111, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
